// File: rtl/dram_init_seq.sv
// Boot-time DRAM configuration sequencer driving the memory hub mgmt port.
// Optional feature: define DRAM_INIT_RETRY_EN to retry the full sequence up to 3 times before ERR.
`ifndef ADDR_MC
`define ADDR_MC 32'h0000_0000
`endif

module dram_init_seq #(
    parameter logic [31:0] BASE_ADR = `ADDR_MC,
    parameter logic [15:0] PWR_DLY  = 16'd20000,
    parameter logic [15:0] TRP_DLY  = 16'd16,
    parameter logic [15:0] CKE_VAL  = 16'h0001,
    parameter logic [15:0] MR_VAL   = 16'h0032,
    parameter logic [15:0] EMR_VAL  = 16'h0000,
    parameter logic [7:0]  POLL_MAX = 8'd64,
    parameter logic [15:0] RSP_TMO  = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reinit,
    output logic        mgmt_req,
    output logic        mgmt_rwn,
    output logic [31:0] mgmt_adr,
    output logic [15:0] mgmt_txd,
    input  logic        mgmt_ack,
    input  logic [15:0] mgmt_rxd,
    input  logic        mgmt_rxe,
    output logic        hub_disable,
    output logic        init_done,
    output logic        init_err
);

    typedef enum logic [3:0] {
        S_PWRUP, S_CKE_WR, S_TRP_WAIT, S_MR_WR, S_EMR_WR,
        S_POLL_RD, S_POLL_RX, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  poll_q, poll_d;
    logic        req_q, req_d;
    logic        rwn_q, rwn_d;
    logic [31:0] adr_q, adr_d;
    logic [15:0] txd_q, txd_d;
    logic        hubdis_q, hubdis_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        fail;
`ifdef DRAM_INIT_RETRY_EN
    logic [1:0]  retry_q, retry_d;
`endif

    // Only the ready bit of STATUS matters.
    logic unused_rxd;
    assign unused_rxd = ^mgmt_rxd[15:1];

    function automatic logic [3:0] reg_idx(input state_t s);
        case (s)
            S_CKE_WR: return 4'd0;
            S_MR_WR:  return 4'd1;
            S_EMR_WR: return 4'd2;
            default:  return 4'd3;
        endcase
    endfunction

    function automatic logic [15:0] reg_val(input state_t s);
        case (s)
            S_CKE_WR: return CKE_VAL;
            S_MR_WR:  return MR_VAL;
            S_EMR_WR: return EMR_VAL;
            default:  return 16'h0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_PWRUP;
            cnt_q    <= PWR_DLY - 16'd1;
            tmo_q    <= RSP_TMO - 16'd1;
            poll_q   <= 8'd0;
            req_q    <= 1'b0;
            rwn_q    <= 1'b0;
            adr_q    <= BASE_ADR;
            txd_q    <= 16'h0000;
            hubdis_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef DRAM_INIT_RETRY_EN
            retry_q  <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            poll_q   <= poll_d;
            req_q    <= req_d;
            rwn_q    <= rwn_d;
            adr_q    <= adr_d;
            txd_q    <= txd_d;
            hubdis_q <= hubdis_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef DRAM_INIT_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        poll_d   = poll_q;
        req_d    = req_q;
        rwn_d    = rwn_q;
        adr_d    = adr_q;
        txd_d    = txd_q;
        hubdis_d = hubdis_q;
        done_d   = done_q;
        err_d    = err_q;
        fail     = 1'b0;
`ifdef DRAM_INIT_RETRY_EN
        retry_d  = retry_q;
`endif

        case (state_q)
            // Leaving a wait raises the request at once; no previous request to separate from.
            S_PWRUP, S_TRP_WAIT: begin
                if (cnt_q == 16'd0) begin
                    state_d = (state_q == S_PWRUP) ? S_CKE_WR : S_MR_WR;
                    tmo_d   = RSP_TMO - 16'd1;
                    req_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_CKE_WR, S_MR_WR, S_EMR_WR, S_POLL_RD: begin
                if (req_q && mgmt_ack) begin
                    req_d = 1'b0;
                    tmo_d = RSP_TMO - 16'd1;
                    case (state_q)
                        S_CKE_WR: begin
                            state_d = S_TRP_WAIT;
                            cnt_d   = TRP_DLY - 16'd1;
                        end
                        S_MR_WR:  state_d = S_EMR_WR;
                        S_EMR_WR: state_d = S_POLL_RD;
                        default:  state_d = S_POLL_RX;
                    endcase
                end else if (tmo_q == 16'd0) begin
                    fail = 1'b1;
                end else begin
                    // A request state entered with req low spends one idle cycle first.
                    tmo_d = tmo_q - 16'd1;
                    req_d = 1'b1;
                end
            end
            S_POLL_RX: begin
                if (mgmt_rxe) begin
                    if (mgmt_rxd[0]) begin
                        state_d  = S_DONE;
                        hubdis_d = 1'b0;
                        done_d   = 1'b1;
                    end else if (poll_q + 8'd1 == POLL_MAX) begin
                        poll_d = poll_q + 8'd1;
                        fail   = 1'b1;
                    end else begin
                        poll_d  = poll_q + 8'd1;
                        state_d = S_POLL_RD;
                        tmo_d   = RSP_TMO - 16'd1;
                    end
                end else if (tmo_q == 16'd0) begin
                    fail = 1'b1;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
            end
            S_DONE, S_ERR: begin
                if (reinit) begin
                    state_d  = S_PWRUP;
                    cnt_d    = TRP_DLY - 16'd1;
                    hubdis_d = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    poll_d   = 8'd0;
`ifdef DRAM_INIT_RETRY_EN
                    retry_d  = 2'd0;
`endif
                end
            end
            default: state_d = S_ERR;
        endcase

        if (fail) begin
            req_d = 1'b0;
`ifdef DRAM_INIT_RETRY_EN
            if (retry_q != 2'd3) begin
                retry_d = retry_q + 2'd1;
                state_d = S_PWRUP;
                cnt_d   = TRP_DLY - 16'd1;
                poll_d  = 8'd0;
            end else begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end
`else
            state_d = S_ERR;
            err_d   = 1'b1;
`endif
        end

        // Request fields are captured only as req rises, so they hold while req is high.
        if (req_d && !req_q) begin
            rwn_d = (state_d == S_POLL_RD);
            adr_d = BASE_ADR | {28'd0, reg_idx(state_d)};
            txd_d = reg_val(state_d);
        end
    end

    assign mgmt_req    = req_q;
    assign mgmt_rwn    = rwn_q;
    assign mgmt_adr    = adr_q;
    assign mgmt_txd    = txd_q;
    assign hub_disable = hubdis_q;
    assign init_done   = done_q;
    assign init_err    = err_q;

endmodule

// File: tb/tb_dram_init_seq.sv
// Self-checking bench for dram_init_seq: hub model, scenario table, random scenarios, corner sequences.
`timescale 1ns/1ps
module tb_dram_init_seq;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int PMAX = 3;
`ifdef DRAM_INIT_RETRY_EN
    localparam int NSEQ = 4;
`else
    localparam int NSEQ = 1;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, reinit = 1'b0;
    logic        mgmt_req, mgmt_rwn;
    logic [31:0] mgmt_adr;
    logic [15:0] mgmt_txd;
    logic        mgmt_ack = 1'b0, mgmt_rxe = 1'b0;
    logic [15:0] mgmt_rxd = 16'h0;
    logic        hub_disable, init_done, init_err;

    int n_chk = 0, n_pass = 0;
    int block_idx = -1, ready_after = 0, rd_cnt = 0;
    logic [48:0] log_q[$];
    logic [48:0] exp_q[$];

    typedef struct {
        int ready_after;
        int block_idx;
        bit exp_done;
        int exp_ntrans;
    } vec_t;
    vec_t tbl[7];

    dram_init_seq #(
        .BASE_ADR(BASE), .PWR_DLY(16'd8), .TRP_DLY(16'd4),
        .POLL_MAX(8'd3), .RSP_TMO(16'd16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .reinit(reinit),
        .mgmt_req(mgmt_req), .mgmt_rwn(mgmt_rwn), .mgmt_adr(mgmt_adr), .mgmt_txd(mgmt_txd),
        .mgmt_ack(mgmt_ack), .mgmt_rxd(mgmt_rxd), .mgmt_rxe(mgmt_rxe),
        .hub_disable(hub_disable), .init_done(init_done), .init_err(init_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Hub: acks 2 cycles after req (unless the register index is blocked), returns read data 1 cycle later.
    initial begin : hub
        int age;
        int rx_wait;
        logic prev_req, prev_ack;
        logic [48:0] prev_f;
        age = 0; rx_wait = 0; prev_req = 0; prev_ack = 0; prev_f = '0;
        forever begin
            @(posedge clk); #1;
            mgmt_ack = 1'b0;
            mgmt_rxe = 1'b0;
            if (!rst_n) begin
                age = 0; rx_wait = 0; prev_req = 0; prev_ack = 0;
            end else begin
                if (prev_ack) check("req_drop_after_ack", mgmt_req, 0);
                else if (prev_req && mgmt_req)
                    check("req_fields_stable", {mgmt_rwn, mgmt_adr, mgmt_txd}, prev_f);
                prev_ack = 0;
                if (rx_wait > 0) begin
                    rx_wait--;
                    if (rx_wait == 0) begin
                        mgmt_rxe = 1'b1;
                        mgmt_rxd = (rd_cnt >= ready_after) ? (16'($urandom) | 16'h0001)
                                                           : (16'($urandom) & 16'hFFFE);
                        rd_cnt++;
                    end
                end
                age = mgmt_req ? age + 1 : 0;
                if (age == 2 && int'(mgmt_adr[3:0]) != block_idx) begin
                    mgmt_ack = 1'b1;
                    prev_ack = 1;
                    log_q.push_back({mgmt_rwn, mgmt_adr, mgmt_txd});
                    if (mgmt_rwn) rx_wait = 1;
                end
                prev_req = mgmt_req;
                prev_f   = {mgmt_rwn, mgmt_adr, mgmt_txd};
            end
        end
    end

    // Reference: ordered list of accepted transactions and final outcome from the sequencing rules.
    function automatic void model(input int ra, input int blk, output bit done);
        int reads;
        bit failed;
        logic [15:0] wval[3];
        wval[0] = 16'h0001; wval[1] = 16'h0032; wval[2] = 16'h0000;
        reads = 0;
        done = 0;
        exp_q.delete();
        for (int a = 0; a < NSEQ; a++) begin
            failed = 0;
            for (int i = 0; i < 3; i++) begin
                if (i == blk) begin failed = 1; break; end
                exp_q.push_back({1'b0, BASE | 32'(i), wval[i]});
            end
            if (failed) continue;
            for (int p = 0; p < PMAX; p++) begin
                if (blk == 3) break;
                exp_q.push_back({1'b1, BASE | 32'd3, 16'h0000});
                if (reads >= ra) begin done = 1; return; end
                reads++;
            end
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        log_q.delete();
        rd_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_end(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (init_done || init_err) begin ok = 1; break; end
        end
    endtask

    task automatic cmp_log(input string tag);
        check({tag, "_ntrans"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check({tag, "_trans"}, log_q[i], exp_q[i]);
    endtask

    task automatic run_scn(input string tag, input int ra, input int blk, output bit md);
        bit ok;
        block_idx = blk;
        ready_after = ra;
        do_reset();
        model(ra, blk, md);
        wait_end(ok);
        check({tag, "_finished"}, ok, 1);
        check({tag, "_done"}, init_done, md);
        check({tag, "_err"}, init_err, !md);
        check({tag, "_hub_disable"}, hub_disable, !md);
        cmp_log(tag);
    endtask

    initial begin : main
        bit md, ok;
        int n;
        tbl[0] = '{0,    -1, 1'b1, 4};
        tbl[1] = '{1,    -1, 1'b1, 5};
        tbl[2] = '{2,    -1, 1'b1, 6};
        tbl[3] = '{1000, -1, 1'b0, 6 * NSEQ};
        tbl[4] = '{0,     1, 1'b0, 1 * NSEQ};
        tbl[5] = '{0,     3, 1'b0, 3 * NSEQ};
        tbl[6] = '{0,     0, 1'b0, 0};

        // Reset state and power-up latency
        block_idx = -1; ready_after = 0; rd_cnt = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #2;
        check("rst_req", mgmt_req, 0);
        check("rst_rwn", mgmt_rwn, 0);
        check("rst_adr", mgmt_adr, BASE);
        check("rst_txd", mgmt_txd, 0);
        check("rst_hub_disable", hub_disable, 1);
        check("rst_done", init_done, 0);
        check("rst_err", init_err, 0);
        log_q.delete();
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!mgmt_req && n < 50);
        check("first_req_delay", n, 8);
        check("first_req_adr", mgmt_adr, BASE);
        check("first_req_txd", mgmt_txd, 16'h0001);
        check("first_req_rwn", mgmt_rwn, 0);
        wait_end(ok);
        model(0, -1, md);
        check("nom_finished", ok, 1);
        check("nom_done", init_done, 1);
        check("nom_hub_disable", hub_disable, 0);
        cmp_log("nom");

        // Reinit from DONE: short wait, full sequence again
        log_q.delete(); rd_cnt = 0;
        reinit = 1'b1;
        @(posedge clk); #2;
        reinit = 1'b0;
        check("reinit_hub_disable", hub_disable, 1);
        check("reinit_done_clr", init_done, 0);
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!mgmt_req && n < 50);
        check("reinit_wait", n, 4);
        wait_end(ok);
        check("reinit_finished", ok, 1);
        check("reinit_done", init_done, 1);
        cmp_log("reinit");

        // Reinit during POLL_RX is ignored
        block_idx = -1; ready_after = 0;
        do_reset();
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!(mgmt_ack && mgmt_rwn) && n < 200);
        check("rx_read_ack_seen", n < 200, 1);
        @(posedge clk); #2; reinit = 1'b1;
        @(posedge clk); #2; reinit = 1'b0;
        check("rx_reinit_done", init_done, 1);
        check("rx_reinit_hub_disable", hub_disable, 0);
        repeat (6) @(posedge clk); #2;
        check("rx_reinit_still_done", init_done, 1);
        check("rx_reinit_ntrans", log_q.size(), 4);

        // MR write never acked: req drops 16 cycles after entry
        block_idx = 1; ready_after = 0;
        do_reset();
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!(mgmt_req && mgmt_adr[3:0] == 4'd1) && n < 200);
        check("tmo_mr_req_seen", n < 200, 1);
        n = 0;
        do begin @(posedge clk); #2; n++; end while (mgmt_req && n < 100);
        check("tmo_req_drop_delay", n, 16);
        wait_end(ok);
        check("tmo_err", init_err, 1);
        check("tmo_hub_disable", hub_disable, 1);

        // Asynchronous reset in the middle of a write
        block_idx = -1;
        do_reset();
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!mgmt_req && n < 50);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_req", mgmt_req, 0);
        check("async_rst_hub_disable", hub_disable, 1);
        check("async_rst_adr", mgmt_adr, BASE);
        check("async_rst_txd", mgmt_txd, 0);

        // Scenario table
        for (int t = 0; t < 7; t++) begin
            run_scn($sformatf("tbl%0d", t), tbl[t].ready_after, tbl[t].block_idx, md);
            check($sformatf("tbl%0d_exp_done", t), init_done, tbl[t].exp_done);
            check($sformatf("tbl%0d_exp_ntrans", t), log_q.size(), tbl[t].exp_ntrans);
        end

        // Randomized scenarios against the model
        for (int r = 0; r < 12; r++) begin
            int ra, blk;
            ra  = $urandom_range(0, 4);
            blk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            run_scn($sformatf("rnd%0d", r), ra, blk, md);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
